// File: rtl/spi_dac_responder.sv
// SPI target end of the DAC configuration link (mode 0, MSB first).
// Oversamples sck/cs_n/mosi in the dac_clk domain; decodes 24-bit frames
// {R/nW, 3 reserved, addr, data} into a write strobe, and optionally serves
// readback data on MISO from a local register file.
// Optional feature macro: RESP_READBACK_EN (register file + MISO readback).
// Ports:
//   dac_clk, rst_n              system clock, synchronous active-low reset
//   dac_sck_i/cs_n_i/mosi_i     SPI pins from the master (asynchronous)
//   dac_miso_o                  SPI data to master (registered)
//   wr_valid, wr_addr, wr_data  one-cycle committed-write strobe and payload
//   frame_err                   one-cycle strobe for a malformed frame
//   frame_cnt                   count of good frames (wrapping)
module spi_dac_responder #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              dac_clk,
  input  logic              rst_n,
  input  logic              dac_sck_i,
  input  logic              dac_cs_n_i,
  input  logic              dac_mosi_i,
  output logic              dac_miso_o,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BIT_CNT_W = $clog2(FRAME_BITS + 2);
  localparam int unsigned HDR_BITS  = 8;
  localparam int unsigned DEPTH     = 1 << ADDR_W;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t state, state_nxt;

  // 2-FF synchronizers plus a third stage for edge detection; [0] is stage 1
  logic [2:0] sck_sync, cs_sync, mosi_sync;

  always_ff @(posedge dac_clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sck_sync  <= {sck_sync[1:0], dac_sck_i};
      cs_sync   <= {cs_sync[1:0], dac_cs_n_i};
      mosi_sync <= {mosi_sync[1:0], dac_mosi_i};
    end
  end

  logic sck_rise, cs_rise, cs_fall, cs_n_s, mosi_s;
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign cs_rise  = cs_sync[1] & ~cs_sync[2];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];
  assign cs_n_s   = cs_sync[1];
  assign mosi_s   = mosi_sync[2];

  logic start_c, shift_c, commit_c;

  always_ff @(posedge dac_clk) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= state_nxt;
  end

  // Next state; an sck rise coincident with a cs_n edge is never counted
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    shift_c   = 1'b0;
    commit_c  = 1'b0;
    unique case (state)
      WAIT_IDLE: if (cs_n_s) state_nxt = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          start_c   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          commit_c  = 1'b1;
        end else if (sck_rise) begin
          shift_c = 1'b1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  logic [FRAME_BITS-1:0] shreg;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  // Receive shifter and saturating bit counter
  always_ff @(posedge dac_clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (start_c) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_c) begin
      shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt != BIT_CNT_W'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  logic              frame_good, frame_rd;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              unused_rsvd;
  assign frame_good  = (bit_cnt == BIT_CNT_W'(FRAME_BITS));
  assign frame_rd    = shreg[FRAME_BITS-1];
  assign frame_addr  = shreg[DATA_W +: ADDR_W];
  assign frame_data  = shreg[DATA_W-1:0];
  assign unused_rsvd = ^shreg[FRAME_BITS-2:DATA_W+ADDR_W];

`ifdef RESP_READBACK_EN
  logic [DATA_W-1:0] regs [DEPTH];
`endif

  // Frame commit: strobes, write payload, good-frame counter, register file
  always_ff @(posedge dac_clk) begin
    if (!rst_n) begin
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
`ifdef RESP_READBACK_EN
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
`endif
    end else begin
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (commit_c) begin
        if (frame_good) begin
          frame_cnt <= frame_cnt + CNT_W'(1);
          if (!frame_rd) begin
            wr_valid <= 1'b1;
            wr_addr  <= frame_addr;
            wr_data  <= frame_data;
`ifdef RESP_READBACK_EN
            regs[frame_addr] <= frame_data;
`endif
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

`ifdef RESP_READBACK_EN
  localparam int unsigned TX_CNT_W = $clog2(DATA_W + 1);

  logic              sck_fall, load_c;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] tx_shift;
  logic [TX_CNT_W-1:0] tx_left;

  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  // Header completes on the 8th rise: shreg holds the first 7 bits, mosi the 8th
  assign rd_addr  = {shreg[ADDR_W-2:0], mosi_s};
  assign load_c   = shift_c && (bit_cnt == BIT_CNT_W'(HDR_BITS - 1)) && shreg[HDR_BITS-2];

  // Readback shifter: loaded at header end, one bit per sck fall afterwards
  always_ff @(posedge dac_clk) begin
    if (!rst_n) begin
      dac_miso_o <= 1'b0;
      tx_shift   <= '0;
      tx_left    <= '0;
    end else if (state != SHIFT || cs_rise) begin
      dac_miso_o <= 1'b0;
      tx_left    <= '0;
    end else if (load_c) begin
      tx_shift <= regs[rd_addr];
      tx_left  <= TX_CNT_W'(DATA_W);
    end else if (sck_fall) begin
      if (tx_left != '0) begin
        dac_miso_o <= tx_shift[DATA_W-1];
        tx_shift   <= {tx_shift[DATA_W-2:0], 1'b0};
        tx_left    <= tx_left - TX_CNT_W'(1);
      end else begin
        dac_miso_o <= 1'b0;
      end
    end
  end
`else
  assign dac_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_responder.sv
module tb_spi_dac_responder;

  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CNT_W      = 16;

`ifdef RESP_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, sck, cs_n, mosi;
  logic miso, wr_valid, frame_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  frame_cnt;

  spi_dac_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .CNT_W(CNT_W)
  ) dut (
    .dac_clk(clk), .rst_n(rst_n), .dac_sck_i(sck), .dac_cs_n_i(cs_n),
    .dac_mosi_i(mosi), .dac_miso_o(miso), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0, err_pulses = 0;
  int exp_wr_pulses = 0, exp_err_pulses = 0;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) wr_pulses++;
    if (frame_err === 1'b1) err_pulses++;
  end

  // Reference model state
  logic [15:0] m_regs [16];
  logic [15:0] m_cnt;
  logic [3:0]  last_a;
  logic [15:0] last_d;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    bit          coinc;
    bit          ewr;
    bit          eerr;
    logic [3:0]  ea;
    logic [15:0] ed;
    logic [15:0] ecnt;
    logic [31:0] emiso;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_cnt  = '0;
    last_a = '0;
    last_d = '0;
  endtask

  // Predicts one frame from the frame rules, then applies its effect
  task automatic model_frame(input logic [31:0] bits, input int nbits,
                             output bit ewr, output bit eerr, output logic [3:0] ea,
                             output logic [15:0] ed, output logic [15:0] ecnt,
                             output logic [31:0] emiso);
    int c;
    bit hdr_rd;
    logic [3:0] ra;
    logic [15:0] rv;
    bit b;
    c      = (nbits > 25) ? 25 : nbits;
    hdr_rd = (nbits >= 8) && bits[nbits-1];
    ra     = (nbits >= 8) ? bits[nbits-5 -: 4] : 4'd0;
    rv     = m_regs[ra];
    emiso  = '0;
    for (int i = 0; i < nbits; i++) begin
      b = hdr_rd && (i >= 8) && (i < 24) && rv[23-i];
      emiso = {emiso[30:0], b};
    end
    ewr = 1'b0; eerr = 1'b0; ea = '0; ed = '0;
    if (c == 24) begin
      m_cnt = m_cnt + 16'd1;
      if (!bits[23]) begin
        ewr = 1'b1;
        ea  = bits[19:16];
        ed  = bits[15:0];
        m_regs[ea] = ed;
      end
    end else begin
      eerr = 1'b1;
    end
    ecnt = m_cnt;
  endtask

  // Mode 0 master: drive mosi, hold half a period, sample miso, raise sck
  task automatic send_bits(input logic [31:0] bits, input int nbits, input int from,
                           input int upto, inout logic [31:0] mv);
    for (int i = from; i < upto; i++) begin
      mosi = bits[nbits-1-i];
      repeat (4) @(negedge clk);
      mv  = {mv[30:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [31:0] bits, input int nbits, input bit coinc,
                           output logic [31:0] mv, output logic [5:0] wp,
                           output logic [5:0] fp, output logic [3:0] ac,
                           output logic [15:0] dc);
    mv = '0; ac = '0; dc = '0;
    @(negedge clk);
    cs_n = 1'b0;
    if (coinc) sck = 1'b1;
    repeat (4) @(negedge clk);
    if (coinc) begin
      sck = 1'b0;
      repeat (4) @(negedge clk);
    end
    send_bits(bits, nbits, 0, nbits, mv);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wp[k] = wr_valid;
      fp[k] = frame_err;
      if (k == 2) begin
        ac = wr_addr;
        dc = wr_data;
      end
    end
  endtask

  task automatic verify(input string tag, input logic [31:0] bits, input int nbits,
                        input bit coinc, input bit use_model, input bit t_wr,
                        input bit t_err, input logic [3:0] t_a, input logic [15:0] t_d,
                        input logic [15:0] t_cnt, input logic [31:0] t_miso);
    bit m_wr, m_err, ewr, eerr;
    logic [3:0] m_a, ea, ac;
    logic [15:0] m_d, m_c, ed, ecnt, dc;
    logic [31:0] m_mv, emiso, mv;
    logic [5:0] wp, fp;
    model_frame(bits, nbits, m_wr, m_err, m_a, m_d, m_c, m_mv);
    if (use_model) begin
      ewr = m_wr; eerr = m_err; ea = m_a; ed = m_d; ecnt = m_c; emiso = m_mv;
    end else begin
      ewr = t_wr; eerr = t_err; ea = t_a; ed = t_d; ecnt = t_cnt; emiso = t_miso;
    end
    if (ewr) begin
      last_a = ea;
      last_d = ed;
      exp_wr_pulses++;
    end
    if (eerr) exp_err_pulses++;
    run_frame(bits, nbits, coinc, mv, wp, fp, ac, dc);
    check({tag, ".wr_valid"}, 32'(wp), ewr ? 32'h4 : 32'h0);
    check({tag, ".frame_err"}, 32'(fp), eerr ? 32'h4 : 32'h0);
    check({tag, ".wr_addr"}, 32'(ac), 32'(last_a));
    check({tag, ".wr_data"}, 32'(dc), 32'(last_d));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(ecnt));
    check({tag, ".miso"}, mv, RB_EN ? emiso : 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fb, mv;
    int nb;
    int w0, e0;

    tbl[0]  = '{32'h05A5A5,   24, 1'b0, 1'b1, 1'b0, 4'h5, 16'hA5A5, 16'd1,  32'h0};
    tbl[1]  = '{32'h850000,   24, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    16'd2,  32'h0000A5A5};
    tbl[2]  = '{32'h03FFF,    20, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0,    16'd2,  32'h0};
    tbl[3]  = '{32'h830000,   24, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    16'd3,  32'h0};
    tbl[4]  = '{32'h0A2469,   25, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0,    16'd3,  32'h0};
    tbl[5]  = '{32'h850000,   24, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    16'd4,  32'h0000A5A5};
    tbl[6]  = '{32'h10A0000,  25, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0,    16'd4,  32'h00014B4A};
    tbl[7]  = '{32'h071357,   24, 1'b1, 1'b1, 1'b0, 4'h7, 16'h1357, 16'd5,  32'h0};
    tbl[8]  = '{32'h870000,   24, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    16'd6,  32'h00001357};
    tbl[9]  = '{32'h051111,   24, 1'b0, 1'b1, 1'b0, 4'h5, 16'h1111, 16'd7,  32'h0};
    tbl[10] = '{32'h850000,   24, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    16'd8,  32'h00001111};
    tbl[11] = '{32'hF5FFFF,   24, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    16'd9,  32'h00001111};
    tbl[12] = '{32'h7ABEEF,   24, 1'b0, 1'b1, 1'b0, 4'hA, 16'hBEEF, 16'd10, 32'h0};
    tbl[13] = '{32'h85,        8, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0,    16'd10, 32'h0};

    model_reset();
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.wr_valid", 32'(wr_valid), 32'h0);
    check("reset.frame_err", 32'(frame_err), 32'h0);
    check("reset.wr_addr", 32'(wr_addr), 32'h0);
    check("reset.wr_data", 32'(wr_data), 32'h0);
    check("reset.frame_cnt", 32'(frame_cnt), 32'h0);
    check("reset.miso", 32'(miso), 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      verify($sformatf("vec%0d", i), tbl[i].bits, tbl[i].nbits, tbl[i].coinc, 1'b0,
             tbl[i].ewr, tbl[i].eerr, tbl[i].ea, tbl[i].ed, tbl[i].ecnt, tbl[i].emiso);
    end

    // sck activity with cs_n high must do nothing
    w0 = wr_pulses; e0 = err_pulses;
    repeat (3) begin
      sck = 1'b1; mosi = ~mosi;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("idle_sck.strobes", 32'((wr_pulses - w0) + (err_pulses - e0)), 32'h0);
    check("idle_sck.frame_cnt", 32'(frame_cnt), 32'd10);

    // Reset at bit 10 of a write frame; the remainder must be ignored
    w0 = wr_pulses; e0 = err_pulses;
    fb = 32'h0F1234; mv = '0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_bits(fb, 24, 0, 10, mv);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_bits(fb, 24, 10, 24, mv);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    model_reset();
    check("midreset.strobes", 32'((wr_pulses - w0) + (err_pulses - e0)), 32'h0);
    check("midreset.frame_cnt", 32'(frame_cnt), 32'h0);
    check("midreset.wr_addr", 32'(wr_addr), 32'h0);
    check("midreset.wr_data", 32'(wr_data), 32'h0);
    verify("post_reset_wr", 32'h0F1234, 24, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 16'h1234, 16'd1, 32'h0);
    verify("post_reset_rd", 32'h8F0000, 24, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 16'd2, 32'h00001234);

    // Randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      nb = ($urandom_range(0, 9) < 7) ? 24 : int'($urandom_range(8, 30));
      fb = $urandom & ((32'h1 << nb) - 32'h1);
      verify($sformatf("rand%0d", n), fb, nb, 1'b0, 1'b1,
             1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 32'h0);
    end

    repeat (4) @(negedge clk);
    check("total.wr_pulses", 32'(wr_pulses), 32'(exp_wr_pulses));
    check("total.err_pulses", 32'(err_pulses), 32'(exp_err_pulses));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_dac_responder.md
Name: spi_dac_responder

Overview:
- SPI target (slave) end of the DAC configuration link. It receives the frames the DAC-config SPI master sends on dac_sck/dac_cs_n/dac_mosi and answers on dac_miso.
- Used as an on-chip DAC emulator and loopback target for bring-up of the configuration path. It decodes write frames into a register file plus a write strobe, and serves readback frames on MISO.
- All pins are oversampled in the dac_clk domain. No SCK-clocked logic.

Parameters:
- ADDR_W, 4, register address width; register file holds 2^ADDR_W entries.
- DATA_W, 16, register data width.
- FRAME_BITS, 24, legal frame length. Must equal 8 + DATA_W.
- CNT_W, 16, width of frame_cnt.

Ports:
- dac_clk  input  1  system clock. Must be >= 4x SCK frequency.
- rst_n  input  1  reset, synchronous, active-low.
- dac_sck_i  input  1  SPI clock from master. Mode 0: CPOL=0, sample on rising edge, shift on falling edge.
- dac_cs_n_i  input  1  SPI chip select, active-low.
- dac_mosi_i  input  1  SPI data from master, MSB first.
- dac_miso_o  output  1  SPI data to master, registered.
- wr_valid  output  1  one-cycle strobe for a committed write.
- wr_addr  output  ADDR_W  address of the committed write.
- wr_data  output  DATA_W  data of the committed write.
- frame_err  output  1  one-cycle strobe for a malformed frame.
- frame_cnt  output  CNT_W  count of good frames. Wraps at 2^CNT_W.

Behaviour:
- Frame layout, MSB first: bit23 = R/nW (1 = read); bits22:20 reserved, ignored; bits19:16 = address; bits15:0 = data.
- Input sync: sck, cs_n and mosi each pass through a 2-FF synchronizer. Edges are detected from stage2 vs stage3. mosi is sampled from stage3 on a detected sck rise.
- Reset values: dac_miso_o=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, frame_cnt=0, all registers=0, bit counter=0.
- After reset: state WAIT_IDLE.
- FSM transitions:
  - WAIT_IDLE -> IDLE when synced cs_n=1. A frame already in progress at reset release is ignored.
  - IDLE -> SHIFT on synced cs_n fall. Clears the bit counter and shift register.
  - SHIFT: each sck rise shifts in mosi and increments the counter, saturating at FRAME_BITS+1.
  - SHIFT -> IDLE on synced cs_n rise. Commit rules on that transition:
    - count == FRAME_BITS and write: register[addr] <= data; wr_valid=1 with wr_addr/wr_data; frame_cnt+1.
    - count == FRAME_BITS and read: frame_cnt+1; no write.
    - count != FRAME_BITS (short or overrun): frame_err=1; no write; frame_cnt unchanged.
- Commit latency: wr_valid/frame_err are registered on the 3rd dac_clk rising edge, counting the first edge that samples dac_cs_n_i=1. They are high for exactly one cycle.
- wr_addr/wr_data hold their last committed value between strobes.
- sck edges while cs_n is high are ignored.
- A cs_n fall coincident with a detected sck rise starts the frame without counting that edge.
- Readback timing:
  - Counter reaches 8 on a read frame: load register[addr] into the TX shifter.
  - On the next sck fall (8th fall), drive bit DATA_W-1 on dac_miso_o.
  - Each subsequent sck fall shifts one bit.
- dac_miso_o=0 in these cases:
  - before the readback window;
  - during write frames;
  - after all DATA_W bits;
  - from the cycle cs_n rise is detected.
- A write to an address in the same cycle the readback is loaded returns the old value; register writes only occur at frame end.
- MOSI data bits of a read frame are ignored.

Optional Feature:
- Macro RESP_READBACK_EN.
- Defined: register file stored; read frames return register contents on MISO as described above.
- Undefined: no register storage; dac_miso_o tied 0. Write frames still produce wr_valid/wr_addr/wr_data. Read frames are still counted in frame_cnt.

Test Plan:
- Reset then write frame 0x05A5A5 (24 bits, SCK = dac_clk/8) -> one wr_valid with wr_addr=5, wr_data=0xA5A5; frame_cnt=1; frame_err stays 0.
- After write above, read frame 0x850000 -> MISO bits 8..23 sampled by master on rising edges give 0xA5A5; bits 0..7 read 0; frame_cnt=2; no wr_valid.
- Frame of 20 bits 0x03FFF then cs_n high -> frame_err one cycle; no wr_valid; subsequent read of addr 3 returns 0x0000.
- 25-bit frame -> frame_err; register unchanged; frame_cnt unchanged.
- rst_n low for 2 cycles at bit 10 of a write frame, cs_n still low -> remainder ignored, no strobes; next full write 0x0F1234 commits addr F = 0x1234.
- RESP_READBACK_EN undefined: write 0x051111, read addr 5 -> wr_valid seen; MISO constant 0; frame_cnt=2.
